// File: rtl/serial_multiplier_param.sv
// serial_multiplier_param: shift-add serial multiplier retiring one multiplier
// bit per clock, with per-operation signed/unsigned mode and valid/ready
// handshakes on both sides. The product register holds its value until the
// next completion or reset.
// Optional build macro SERIAL_MULT_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are all zero, and report the RUN cycle count on
// busy_cycles.
module serial_multiplier_param #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multin1,
    input  logic [WIDTH-1:0]     multin2,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SERIAL_MULT_EARLY_TERM_EN
    output logic [CNT_W:0]       busy_cycles,
`endif
    output logic [2*WIDTH-1:0]   multout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     mcand, mplier;
    logic [WIDTH-1:0]     mag1, mag2;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc, acc_next, addend, result;
    logic [CNT_W-1:0]     count;
    logic                 last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand magnitudes at capture; |-2^(WIDTH-1)| wraps to 2^(WIDTH-1) unsigned.
    always_comb begin
        mag1 = (is_signed && multin1[WIDTH-1]) ? -multin1 : multin1;
        mag2 = (is_signed && multin2[WIDTH-1]) ? -multin2 : multin2;
    end

    // One partial-product step plus sign fix-up and the RUN exit condition.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        addend   = {{WIDTH{1'b0}}, mcand} << count;
        acc_next = mplier[0] ? acc + addend : acc;
        result   = neg ? -acc_next : acc_next;
        last     = (count == CNT_W'(WIDTH - 1));
`ifdef SERIAL_MULT_EARLY_TERM_EN
        // Remaining multiplier bits after this shift are all zero.
        if (mplier[WIDTH-1:1] == '0) begin
            last = 1'b1;
        end
`endif
    end

    // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from pre-edge values.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand capture, shift-add accumulation and product register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            count   <= '0;
            multout <= '0;
`ifdef SERIAL_MULT_EARLY_TERM_EN
            busy_cycles <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mag1;
                        mplier <= mag2;
                        neg    <= is_signed & (multin1[WIDTH-1] ^ multin2[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last) begin
                        multout <= result;
`ifdef SERIAL_MULT_EARLY_TERM_EN
                        busy_cycles <= {1'b0, count} + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_multiplier_param.sv
// tb_serial_multiplier_param: directed vectors for serial_multiplier_param
// (WIDTH=16). Stimulus pushes each expected product into a queue; a monitor
// pops and compares on every output handshake.
module tb_serial_multiplier_param;

    localparam int WIDTH = 16;
`ifdef SERIAL_MULT_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multin1, multin2;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   multout;
`ifdef SERIAL_MULT_EARLY_TERM_EN
    logic [4:0]           busy_cycles;
`endif

    typedef struct {
        bit            sgn;
        logic [15:0]   a;
        logic [15:0]   b;
        logic [31:0]   p;
        int            lat_et;
    } vec_t;

    vec_t          vecs[$];
    logic [31:0]   exp_q[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    serial_multiplier_param #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .multin1    (multin1),
        .multin2    (multin2),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SERIAL_MULT_EARLY_TERM_EN
        .busy_cycles(busy_cycles),
`endif
        .multout    (multout)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compare every accepted product against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(multout), 64'hDEAD_BEEF_0BAD_0BAD);
                end else begin
                    check("product", 64'(multout), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Issue one operation from IDLE; returns at posedge+1 with out_valid seen
    // (or the cycle budget exhausted).
    task automatic run_op(input string tag, input bit sgn, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] p, input int lat_et);
        int n;
        bit ready_hi;
        int lat;
        lat = EARLY_TERM ? lat_et : WIDTH;
        exp_q.push_back(p);
        is_signed = sgn;
        multin1   = a;
        multin2   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        multin1  = ~a;
        multin2  = ~b;
        n = 0;
        ready_hi = 1'b0;
        while (!out_valid && n < 3 * WIDTH) begin
            if (in_ready) ready_hi = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready) ready_hi = 1'b1;
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_in_ready_low"}, 64'(ready_hi), 64'(0));
`ifdef SERIAL_MULT_EARLY_TERM_EN
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(lat));
`endif
    endtask

    // Expect the output handshake on the next edge and a return to IDLE.
    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
        check({tag, "_out_valid_after"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;

        vecs.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16});
        vecs.push_back('{1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1, 3});
        vecs.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1});
        vecs.push_back('{1'b1, 16'h8000, 16'h8000, 32'h40000000, 16});
        vecs.push_back('{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 1});
        vecs.push_back('{1'b0, 16'h1234, 16'h0003, 32'h0000369C, 2});
        vecs.push_back('{1'b0, 16'h1234, 16'h0000, 32'h00000000, 1});
        vecs.push_back('{1'b1, 16'h0000, 16'hFFFB, 32'h00000000, 3});
        vecs.push_back('{1'b0, 16'h00FF, 16'h0100, 32'h0000FF00, 9});

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        is_signed = 1'b0;
        multin1   = '0;
        multin2   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_multout", 64'(multout), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat_et);
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: product and out_valid hold for 5 clocks, new operands ignored.
        out_ready = 1'b0;
        run_op("bp", 1'b0, 16'h0003, 16'h0005, 32'h0000000F, 3);
        held = multout;
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            is_signed = 1'b0;
            multin1   = 16'h0101 + 16'(k);
            multin2   = 16'h0202 + 16'(k);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp_out_valid_%0d", k), 64'(out_valid), 64'(1));
            check($sformatf("bp_multout_%0d", k), 64'(multout), 64'(held));
        end
        out_ready = 1'b1;
        finish_op("bp");

        // Asynchronous reset mid-RUN at count=7, between clock edges.
        is_signed = 1'b0;
        multin1   = 16'hFFFF;
        multin2   = 16'hFFFF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_multout", 64'(multout), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 1'b0, 16'h1234, 16'h0010, 32'h00012340, 5);
        finish_op("post_rst");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
